temp_output: RTL
================

# temp_output

Output-side counterpart of the temperature digit-entry path. Accepts a 10-bit binary temperature, converts it to three BCD digits with a sequential shift-and-add-3 (double-dabble) engine, then presents the digits one at a time (ones, tens, hundreds) under control of a `next` strobe, mirroring the entry order used on the input side. It sits between the temperature datapath and the digit display / readback logic.

## Interface
- No parameters; widths fixed (10-bit binary in, 3 BCD digits out).
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: reset rst, asynchronous, active-high.
- `load` in 1: one-cycle strobe; sample `bin` and start conversion.
- `bin` in 10: unsigned binary temperature.
- `next` in 1: one-cycle strobe; advance to next presented digit.
- `busy` out 1: conversion in progress.
- `valid` out 1: one-cycle pulse, new BCD result available.
- `overflow` out 1: last loaded `bin` exceeded 999 and was saturated.
- `out_state` out 2: 00 ONES, 01 TENS, 10 HUNS, 11 DONE.
- `digit` out 4: BCD digit currently presented.
- `bcd_ones`, `bcd_tens`, `bcd_huns` out 4 each: full converted result.

## Operation
- Internal states: IDLE, CONV, ONES, TENS, HUNS.
- `out_state` = 00/01/10 in ONES/TENS/HUNS; 11 in IDLE and CONV. Registered state drives it directly.
- Saturation: at load, if `bin` > 999, shift register loaded with 999 and `overflow` set; else `bin` loaded and `overflow` cleared.
- CONV: 10 iterations, one per clock; each iteration adds 3 to every BCD nibble ≥ 5, then shifts the 22-bit {huns,tens,ones,bin} register left by 1. 4-bit iteration counter.
- After 10th iteration: `bcd_*` registers updated, `valid` pulsed, state → ONES.
- `next` in ONES → TENS, TENS → HUNS, HUNS → IDLE. `next` ignored in IDLE and CONV.
- `load` accepted in IDLE, ONES, TENS, HUNS (restart, discards presentation); ignored in CONV.
- `load` and `next` in same cycle: `load` wins.
- `digit` = `bcd_ones`/`bcd_tens`/`bcd_huns` in ONES/TENS/HUNS; 0 in IDLE/CONV.
- `bcd_*` and `overflow` hold their values until the next completed conversion (`overflow` updates at load).

## Timing
- Reset values: state IDLE, `out_state` 11, `busy` 0, `valid` 0, `overflow` 0, `digit` 0, all `bcd_*` 0, counter 0, shift register 0.
- Load accepted at edge E0: state CONV, `busy` = 1 from E0.
- Iterations at edges E1..E10; at E10 `bcd_*` written, `valid` = 1 for exactly the cycle after E10, `busy` = 0, state ONES.
- Latency load-edge to `valid`: 10 cycles. Restarting load in a presenting state behaves identically; `valid` never asserted during CONV.
- `next` at edge: `out_state`/`digit` change in following cycle; one digit per `next`.
- `rst` mid-CONV: immediate return to reset values; no `valid`; partial result discarded.
- All outputs registered except `digit` (mux of registered state and `bcd_*`).

## Test plan
- Reset then `load` `bin`=0 → `valid` 10 cycles later; digits 0,0,0; `overflow`=0; three `next` → out_state 00,01,10, then 11.
- `load` 273 → `bcd_huns/tens/ones`=2/7/3; `digit` sequence 3,7,2 across `next` pulses; IDLE after third `next`.
- `load` 999 and 1023 → both yield 9/9/9; `overflow` 0 for 999, 1 for 1023.
- `load` 456, second `load` 123 at cycle 4 of CONV → ignored; result 4/5/6 at cycle 10; `next` during CONV no effect.
- In TENS after 273, `load` 58 with `next` same cycle → restart wins; 10 cycles later 0/5/8, state ONES, `digit`=8.
- `load` 800, assert `rst` at cycle 6 of CONV → all outputs reset values, no `valid`; subsequent `load` 800 → 8/0/0.

Source files
------------

// File: rtl/temp_output.sv
// Binary-to-BCD output path: double-dabble conversion, then presents
// ones/tens/hundreds digits one at a time under a next strobe.
module temp_output (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [9:0] bin,
  input  logic       next,
  output logic       busy,
  output logic       valid,
  output logic       overflow,
  output logic [1:0] out_state,
  output logic [3:0] digit,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_huns
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_ONES,
    S_TENS,
    S_HUNS
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [21:0] sr;
  logic [21:0] sr_adj;
  logic [21:0] sr_shift;
  logic [3:0]  cnt;
  logic        load_ok;
  logic        last_iter;
  logic [1:0]  out_nx;

  assign load_ok   = load && (state != S_CONV);
  assign last_iter = (state == S_CONV) && (cnt == 4'd9);

  // Add-3 correction on each BCD nibble before the shift.
  always_comb begin
    sr_adj = sr;
    if (sr[13:10] >= 4'd5) sr_adj[13:10] = sr[13:10] + 4'd3;
    if (sr[17:14] >= 4'd5) sr_adj[17:14] = sr[17:14] + 4'd3;
    if (sr[21:18] >= 4'd5) sr_adj[21:18] = sr[21:18] + 4'd3;
    sr_shift = {sr_adj[20:0], 1'b0};
  end

  always_comb begin
    state_nx = state;
    if (load_ok) begin
      state_nx = S_CONV;
    end else begin
      unique case (state)
        S_IDLE: state_nx = S_IDLE;
        S_CONV: if (cnt == 4'd9) state_nx = S_ONES;
        S_ONES: if (next) state_nx = S_TENS;
        S_TENS: if (next) state_nx = S_HUNS;
        S_HUNS: if (next) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_nx = 2'b11;
    unique case (state_nx)
      S_ONES:  out_nx = 2'b00;
      S_TENS:  out_nx = 2'b01;
      S_HUNS:  out_nx = 2'b10;
      default: out_nx = 2'b11;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      out_state <= 2'b11;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      state     <= state_nx;
      out_state <= out_nx;
      busy      <= (state_nx == S_CONV);
      valid     <= last_iter;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (load_ok) begin
      cnt <= '0;
      if (bin > 10'd999) begin
        sr       <= 22'd999;
        overflow <= 1'b1;
      end else begin
        sr       <= {12'b0, bin};
        overflow <= 1'b0;
      end
    end else if (state == S_CONV) begin
      sr  <= sr_shift;
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_ones <= '0;
      bcd_tens <= '0;
      bcd_huns <= '0;
    end else if (last_iter) begin
      bcd_ones <= sr_shift[13:10];
      bcd_tens <= sr_shift[17:14];
      bcd_huns <= sr_shift[21:18];
    end
  end

  always_comb begin
    digit = 4'd0;
    unique case (state)
      S_ONES:  digit = bcd_ones;
      S_TENS:  digit = bcd_tens;
      S_HUNS:  digit = bcd_huns;
      default: digit = 4'd0;
    endcase
  end

endmodule
